// File: rtl/hilo_pkg.sv
// HI/LO controller shared definitions: op encodings, FSM states, funct codes.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package hilo_pkg;

  localparam logic [3:0] HILO_OP_NOP   = 4'd0;
  localparam logic [3:0] HILO_OP_MULT  = 4'd1;
  localparam logic [3:0] HILO_OP_MULTU = 4'd2;
  localparam logic [3:0] HILO_OP_DIV   = 4'd3;
  localparam logic [3:0] HILO_OP_DIVU  = 4'd4;
  localparam logic [3:0] HILO_OP_MADD  = 4'd5;
  localparam logic [3:0] HILO_OP_MADDU = 4'd6;
  localparam logic [3:0] HILO_OP_MSUB  = 4'd7;
  localparam logic [3:0] HILO_OP_MSUBU = 4'd8;
  localparam logic [3:0] HILO_OP_MUL   = 4'd9;
  localparam logic [3:0] HILO_OP_MTHI  = 4'd10;
  localparam logic [3:0] HILO_OP_MTLO  = 4'd11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } hilo_state_t;

  // FUNCT_NOP is kept distinct from every real funct so the unit never
  // mistakes an idle cycle for a start.
  localparam logic [5:0] FUNCT_NOP   = 6'h00;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_MADD  = 6'h1C;
  localparam logic [5:0] FUNCT_MADDU = 6'h1D;
  localparam logic [5:0] FUNCT_MSUB  = 6'h1E;
  localparam logic [5:0] FUNCT_MSUBU = 6'h1F;
  localparam logic [5:0] FUNCT_MUL   = 6'h02;

  // Ops that occupy the multiply/divide unit (MULT through MUL).
  function automatic logic is_arith(input logic [3:0] op);
    return (op >= HILO_OP_MULT) && (op <= HILO_OP_MUL);
  endfunction

  function automatic logic [5:0] op_to_funct(input logic [3:0] op);
    case (op)
      HILO_OP_MULT:  return FUNCT_MULT;
      HILO_OP_MULTU: return FUNCT_MULTU;
      HILO_OP_DIV:   return FUNCT_DIV;
      HILO_OP_DIVU:  return FUNCT_DIVU;
      HILO_OP_MADD:  return FUNCT_MADD;
      HILO_OP_MADDU: return FUNCT_MADDU;
      HILO_OP_MSUB:  return FUNCT_MSUB;
      HILO_OP_MSUBU: return FUNCT_MSUBU;
      HILO_OP_MUL:   return FUNCT_MUL;
      default:       return FUNCT_NOP;
    endcase
  endfunction

endpackage

// File: rtl/hilo_regfile.sv
// HI/LO architectural registers with per-register write enables.
// Latency: write visible next cycle; same cycle when HILO_BYPASS_EN is defined.
// Backpressure: none; writes always accepted.
module hilo_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_wdata,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_wdata,
  output logic [DATA_W-1:0] hi_q,
  output logic [DATA_W-1:0] lo_q,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  // Register update; synchronous active-low reset clears both halves.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

`ifdef HILO_BYPASS_EN
  // Forward the value being written so a dependent MFHI/MFLO needs no bubble.
  always_comb begin
    hi = hi_we ? hi_wdata : hi_q;
    lo = lo_we ? lo_wdata : lo_q;
  end
`else
  // Plain register view; decode inserts the bubble for dependent reads.
  always_comb begin
    hi = hi_q;
    lo = lo_q;
  end
`endif

endmodule

// File: rtl/hilo_ctrl.sv
// HI/LO register file + issue/stall controller for the mul/div unit (optional HILO_BYPASS_EN).
// Latency: issue-to-commit = unit latency + 1; HI/LO visible the cycle after commit.
// Backpressure: stall_req held while an op is in flight, released in the md_done cycle.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int FUNCT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                issue_valid,
  input  logic [3:0]          issue_op,
  input  logic [DATA_W-1:0]   issue_a,
  input  logic [DATA_W-1:0]   issue_b,
  output logic [FUNCT_W-1:0]  md_funct,
  output logic [DATA_W-1:0]   md_op1,
  output logic [DATA_W-1:0]   md_op2,
  output logic [DATA_W-1:0]   md_hi,
  output logic [DATA_W-1:0]   md_lo,
  output logic                md_flush,
  input  logic                md_done,
  input  logic [2*DATA_W-1:0] md_result,
  output logic                stall_req,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo,
  output logic [DATA_W-1:0]   gpr_wdata,
  output logic                gpr_wvalid
);

  hilo_state_t       state;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;

  logic accept;
  logic start;
  logic commit;
  logic commit_hilo;
  logic mthi_we;
  logic mtlo_we;
  logic hi_we;
  logic lo_we;
  logic [DATA_W-1:0] hi_wdata;
  logic [DATA_W-1:0] lo_wdata;

  // Issue/commit qualification; flush suppresses both acceptance and commit.
  always_comb begin
    accept      = (state == ST_IDLE) && issue_valid && !flush;
    start       = accept && is_arith(issue_op);
    mthi_we     = accept && (issue_op == HILO_OP_MTHI);
    mtlo_we     = accept && (issue_op == HILO_OP_MTLO);
    commit      = (state == ST_BUSY) && md_done && !flush;
    commit_hilo = commit && (op_q != HILO_OP_MUL);
    hi_we       = mthi_we || commit_hilo;
    lo_we       = mtlo_we || commit_hilo;
    hi_wdata    = commit_hilo ? md_result[2*DATA_W-1:DATA_W] : issue_a;
    lo_wdata    = commit_hilo ? md_result[DATA_W-1:0]        : issue_a;
  end

  // Unit drive: latched op while busy, live issue on the start cycle, else NOP.
  always_comb begin
    md_funct  = FUNCT_W'(FUNCT_NOP);
    md_op1    = a_q;
    md_op2    = b_q;
    stall_req = 1'b0;
    if (state == ST_BUSY) begin
      md_funct  = FUNCT_W'(op_to_funct(op_q));
      stall_req = !md_done && !flush;
    end else if (start) begin
      md_funct  = FUNCT_W'(op_to_funct(issue_op));
      md_op1    = issue_a;
      md_op2    = issue_b;
      stall_req = 1'b1;
    end
    md_flush = flush;
  end

  // Issue/commit FSM with the registered GPR write strobe for MUL.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      op_q       <= HILO_OP_NOP;
      a_q        <= '0;
      b_q        <= '0;
      gpr_wvalid <= 1'b0;
      gpr_wdata  <= '0;
    end else begin
      gpr_wvalid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q  <= issue_op;
            a_q   <= issue_a;
            b_q   <= issue_b;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (flush) begin
            state <= ST_IDLE;
          end else if (md_done) begin
            state <= ST_IDLE;
            if (op_q == HILO_OP_MUL) begin
              gpr_wvalid <= 1'b1;
              gpr_wdata  <= md_result[DATA_W-1:0];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  hilo_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .hi_we    (hi_we),
    .hi_wdata (hi_wdata),
    .lo_we    (lo_we),
    .lo_wdata (lo_wdata),
    .hi_q     (md_hi),
    .lo_q     (md_lo),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Randomized + directed bench for hilo_ctrl with an in-bench mul/div unit stub.
// The reference tracks HI/LO and the in-flight transaction at op level.
// Compare process runs once per cycle, half a period away from the active edge.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, issue_valid, md_done;
  logic [3:0]  issue_op;
  logic [31:0] issue_a, issue_b;
  logic [63:0] md_result;
  logic [5:0]  md_funct;
  logic [31:0] md_op1, md_op2, md_hi, md_lo, hi, lo, gpr_wdata;
  logic        md_flush, stall_req, gpr_wvalid;

  always #5 clk = ~clk;

  hilo_ctrl #(.DATA_W(32), .FUNCT_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush), .issue_valid(issue_valid),
    .issue_op(issue_op), .issue_a(issue_a), .issue_b(issue_b),
    .md_funct(md_funct), .md_op1(md_op1), .md_op2(md_op2),
    .md_hi(md_hi), .md_lo(md_lo), .md_flush(md_flush),
    .md_done(md_done), .md_result(md_result), .stall_req(stall_req),
    .hi(hi), .lo(lo), .gpr_wdata(gpr_wdata), .gpr_wvalid(gpr_wvalid)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: architectural HI/LO, in-flight op, GPR strobe, stub timer.
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0, m_gd = 0;
  logic [3:0]  m_op = 0;
  logic        m_busy = 0, m_gv = 0;
  int          s_cnt = 0;
  logic [63:0] s_res = 0;

  int          stall_cnt = 0, gv_cnt = 0;
  logic [31:0] gv_last = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [5:0] ref_funct(input logic [3:0] op);
    case (op)
      HILO_OP_MULT:  return FUNCT_MULT;
      HILO_OP_MULTU: return FUNCT_MULTU;
      HILO_OP_DIV:   return FUNCT_DIV;
      HILO_OP_DIVU:  return FUNCT_DIVU;
      HILO_OP_MADD:  return FUNCT_MADD;
      HILO_OP_MADDU: return FUNCT_MADDU;
      HILO_OP_MSUB:  return FUNCT_MSUB;
      HILO_OP_MSUBU: return FUNCT_MSUBU;
      HILO_OP_MUL:   return FUNCT_MUL;
      default:       return FUNCT_NOP;
    endcase
  endfunction

  // What a correct mul/div unit returns, from plain arithmetic.
  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
    longint sa, sb;
    logic [63:0] sp, up, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    sp  = 64'(sa * sb);
    up  = {32'd0, a} * {32'd0, b};
    acc = {h, l};
    case (op)
      HILO_OP_MULT, HILO_OP_MUL: return sp;
      HILO_OP_MULTU: return up;
      HILO_OP_DIV:   return {32'(sa % sb), 32'(sa / sb)};
      HILO_OP_DIVU:  return {a % b, a / b};
      HILO_OP_MADD:  return acc + sp;
      HILO_OP_MADDU: return acc + up;
      HILO_OP_MSUB:  return acc - sp;
      HILO_OP_MSUBU: return acc - up;
      default:       return 64'd0;
    endcase
  endfunction

  // One clock cycle: drive, predict, compare away from the edge, then advance.
  task automatic step(input logic r, input logic fl, input logic iv, input logic [3:0] op,
                      input logic [31:0] a, input logic [31:0] b, input int lat,
                      input logic sp_done);
    logic acc, ar, hi_w, lo_w, n_busy, n_gv;
    logic [31:0] n_hi, n_lo, n_a, n_b, n_gd, e_hi, e_lo;
    logic [3:0] n_op;
    logic [5:0] e_funct;
    logic chk_funct, e_stall;
    int n_scnt;
    logic [63:0] n_sres;
    @(negedge clk);
    rst = r; flush = fl; issue_valid = iv; issue_op = op; issue_a = a; issue_b = b;
    if (m_busy) begin
      md_done   = (s_cnt == 1);
      md_result = md_done ? s_res : {$urandom, $urandom};
    end else begin
      md_done   = sp_done;
      md_result = {$urandom, $urandom};
    end
    acc = !m_busy && iv && !fl;
    ar  = acc && (op >= HILO_OP_MULT) && (op <= HILO_OP_MUL);
    n_hi = m_hi; n_lo = m_lo; n_a = m_a; n_b = m_b; n_op = m_op; n_gd = m_gd;
    n_busy = m_busy; n_gv = 1'b0; hi_w = 1'b0; lo_w = 1'b0;
    n_scnt = s_cnt; n_sres = s_res;
    if (!r) begin
      n_hi = 0; n_lo = 0; n_busy = 0; n_gd = 0; n_scnt = 0; n_op = 0;
    end else if (m_busy) begin
      if (fl) begin
        n_busy = 0; n_scnt = 0;
      end else if (md_done) begin
        n_busy = 0; n_scnt = 0;
        if (m_op == HILO_OP_MUL) begin
          n_gv = 1'b1; n_gd = s_res[31:0];
        end else begin
          n_hi = s_res[63:32]; n_lo = s_res[31:0]; hi_w = 1'b1; lo_w = 1'b1;
        end
      end else begin
        n_scnt = s_cnt - 1;
      end
    end else if (ar) begin
      n_busy = 1; n_op = op; n_a = a; n_b = b;
      n_scnt = lat; n_sres = ref_res(op, a, b, m_hi, m_lo);
    end else if (acc && op == HILO_OP_MTHI) begin
      n_hi = a; hi_w = 1'b1;
    end else if (acc && op == HILO_OP_MTLO) begin
      n_lo = a; lo_w = 1'b1;
    end
    e_stall   = m_busy ? (!md_done && !fl) : ar;
    chk_funct = !(m_busy && fl);
    e_funct   = m_busy ? ref_funct(m_op) : (ar ? ref_funct(op) : FUNCT_NOP);
`ifdef HILO_BYPASS_EN
    e_hi = hi_w ? n_hi : m_hi;
    e_lo = lo_w ? n_lo : m_lo;
`else
    e_hi = m_hi;
    e_lo = m_lo;
`endif
    #1;
    if (r) begin
      chk("stall_req", stall_req, e_stall);
      chk("md_flush", md_flush, fl);
      chk("md_hi", md_hi, m_hi);
      chk("md_lo", md_lo, m_lo);
      chk("hi", hi, e_hi);
      chk("lo", lo, e_lo);
      chk("gpr_wvalid", gpr_wvalid, m_gv);
      chk("gpr_wdata", gpr_wdata, m_gd);
      if (chk_funct) begin
        chk("md_funct", md_funct, e_funct);
        if (e_funct != FUNCT_NOP) begin
          chk("md_op1", md_op1, m_busy ? m_a : a);
          chk("md_op2", md_op2, m_busy ? m_b : b);
        end
      end
      if (stall_req) stall_cnt++;
      if (gpr_wvalid) begin
        gv_cnt++;
        gv_last = gpr_wdata;
      end
    end
    @(posedge clk);
    m_hi = n_hi; m_lo = n_lo; m_a = n_a; m_b = n_b; m_op = n_op; m_gd = n_gd;
    m_busy = n_busy; m_gv = n_gv; s_cnt = n_scnt; s_res = n_sres;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, HILO_OP_NOP, 0, 0, 1, 0);
  endtask

  initial begin
    rst = 0; flush = 0; issue_valid = 0; issue_op = 0; issue_a = 0; issue_b = 0;
    md_done = 0; md_result = 0;

    // Reset: outputs quiescent and zero.
    step(0, 0, 0, HILO_OP_NOP, 0, 0, 1, 0);
    step(0, 0, 0, HILO_OP_NOP, 0, 0, 1, 0);
    idle(1);
    #2;
    chk("rst_hi", hi, 0); chk("rst_lo", lo, 0);
    chk("rst_stall", stall_req, 0); chk("rst_funct", md_funct, FUNCT_NOP);
    chk("rst_gpr", {gpr_wvalid, gpr_wdata}, 0);

    // MTHI then MTLO back to back, never stalling.
    stall_cnt = 0;
    step(1, 0, 1, HILO_OP_MTHI, 32'h12345678, 0, 1, 0);
    #2 chk("mthi_hi", hi, 32'h12345678);
    step(1, 0, 1, HILO_OP_MTLO, 32'h9ABCDEF0, 0, 1, 0);
    #2 chk("mtlo_lo", lo, 32'h9ABCDEF0);
    chk("mt_stall_cnt", stall_cnt, 0);

    // MULT -2 * 3, unit done two cycles after issue.
    stall_cnt = 0;
    step(1, 0, 1, HILO_OP_MULT, 32'hFFFFFFFE, 3, 2, 0);
    idle(2);
    #2;
    chk("mult_stall_cnt", stall_cnt, 2);
    chk("mult_hi", hi, 32'hFFFFFFFF); chk("mult_lo", lo, 32'hFFFFFFFA);

    // DIV 100 / 7 with a 17-cycle unit.
    stall_cnt = 0;
    step(1, 0, 1, HILO_OP_DIV, 100, 7, 17, 0);
    idle(18);
    #2;
    chk("div_stall_cnt", stall_cnt, 17);
    chk("div_hi", hi, 2); chk("div_lo", lo, 14);

    // MUL 6 * 7 goes to the GPR port only.
    gv_cnt = 0;
    step(1, 0, 1, HILO_OP_MUL, 6, 7, 3, 0);
    idle(5);
    #2;
    chk("mul_pulses", gv_cnt, 1); chk("mul_wdata", gv_last, 42);
    chk("mul_hi", hi, 2); chk("mul_lo", lo, 14);

    // DIV flushed in the cycle its done arrives, then MULTU 5 * 5.
    step(1, 0, 1, HILO_OP_DIV, 32'd1000, 32'd3, 5, 0);
    idle(4);
    step(1, 1, 0, HILO_OP_NOP, 0, 0, 1, 0);
    #2;
    chk("flush_hi", hi, 2); chk("flush_lo", lo, 14);
    step(1, 0, 1, HILO_OP_MULTU, 5, 5, 1, 0);
    idle(1);
    #2;
    chk("multu_lo", lo, 25); chk("multu_hi", hi, 0);

    // Reset mid-BUSY; stray md_done afterwards must be ignored.
    step(1, 0, 1, HILO_OP_MULT, 32'h7, 32'h9, 6, 0);
    idle(2);
    step(0, 0, 0, HILO_OP_NOP, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) step(1, 0, 0, HILO_OP_NOP, 0, 0, 1, 1);
    #2;
    chk("rstbusy_hi", hi, 0); chk("rstbusy_lo", lo, 0);
    chk("rstbusy_stall", stall_req, 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      logic r, fl, iv, sd;
      logic [3:0] op;
      logic [31:0] a, b;
      r  = ($urandom_range(0, 99) != 0);
      fl = ($urandom_range(0, 19) == 0);
      iv = ($urandom_range(0, 1) == 1);
      sd = ($urandom_range(0, 4) == 0);
      op = 4'($urandom_range(0, 11));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (b == 0) b = 1;
      step(r, fl, iv, op, a, b, $urandom_range(1, 6), sd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
